// File: rtl/lenet_pkg.sv
// Shared constants for the lenet memory subsystem.
// Holds client IDs for the DRAM arbiter channels, the number of clients per channel
// and the default DRAM word/address widths.
package lenet_pkg;

    localparam int unsigned NUM_CLIENTS = 2;

    // Read channel clients
    localparam int unsigned RD_WEIGHT = 0;  // weight/bias fetch
    localparam int unsigned RD_FMAP   = 1;  // feature-map fetch

    // Write channel clients
    localparam int unsigned WR_CONV = 0;    // conv/relu output
    localparam int unsigned WR_POOL = 1;    // pool output

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 18;

endpackage

// File: rtl/dram_arbiter_if.sv
// Client-side and DRAM-side signal bundle of the DRAM arbiter.
// slave  : arbiter view (takes client requests and DRAM read data, drives grants and DRAM commands)
// master : environment view (clients plus DRAM model)
// Client i fields of packed vectors live at [i*WIDTH +: WIDTH].
interface dram_arbiter_if
    import lenet_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

    logic [NUM_CLIENTS-1:0]            rd_req;
    logic [NUM_CLIENTS*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_CLIENTS-1:0]            rd_gnt;
    logic [NUM_CLIENTS-1:0]            rd_valid;
    logic [DATA_WIDTH-1:0]             rd_data;

    logic [NUM_CLIENTS-1:0]            wr_req;
    logic [NUM_CLIENTS*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_CLIENTS*DATA_WIDTH-1:0] wr_data;
    logic [NUM_CLIENTS-1:0]            wr_gnt;

    logic                              dram_en_rd;
    logic [ADDR_WIDTH-1:0]             dram_addr_rd;
    logic                              dram_valid;
    logic [DATA_WIDTH-1:0]             dram_data_rd;
    logic                              dram_en_wr;
    logic [ADDR_WIDTH-1:0]             dram_addr_wr;
    logic [DATA_WIDTH-1:0]             dram_data_wr;

    logic                              busy;
    logic                              err;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, dram_valid, dram_data_rd,
        output rd_gnt, rd_valid, rd_data, wr_gnt, dram_en_rd, dram_addr_rd,
               dram_en_wr, dram_addr_wr, dram_data_wr, busy, err
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, dram_valid, dram_data_rd,
        input  rd_gnt, rd_valid, rd_data, wr_gnt, dram_en_rd, dram_addr_rd,
               dram_en_wr, dram_addr_wr, dram_data_wr, busy, err
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a last-granted register.
// Ports: clk, srstn (async active-low), en (allow a grant this cycle),
//        req[1:0] (requests), gnt[1:0] (one-hot combinational grant).
// On a tie the client that was not granted last wins; reset points last at client 1
// so client 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       srstn,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q, last_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end

        last_d = last_q;
        if (gnt[0]) begin
            last_d = 1'b0;
        end else if (gnt[1]) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Shares one DRAM port pair between two read clients and two write clients.
// Ports: clk, srstn (async active-low), bus (dram_arbiter_if.slave) carrying client
// requests/grants, read responses and registered DRAM read/write commands, plus
// busy and sticky err.
// Each channel has its own round-robin arbiter. Read grants push the client ID into an
// in-order FIFO; each dram_valid pops the head and steers the pass-through data to it.
module dram_arbiter
    import lenet_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = 4  // power of 2, >= 2
) (
    input  logic          clk,
    input  logic          srstn,
    dram_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [1:0]            rd_gnt, wr_gnt;
    logic                  rd_eligible, push, pop, head_id;
    logic [ADDR_WIDTH-1:0] rd_sel_addr, wr_sel_addr;
    logic [DATA_WIDTH-1:0] wr_sel_data;

    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  id_mem_q [MAX_OUTSTANDING];
    logic                  err_q;
    logic                  en_rd_q, en_wr_q;
    logic [ADDR_WIDTH-1:0] addr_rd_q, addr_wr_q;
    logic [DATA_WIDTH-1:0] data_wr_q;

    // A full FIFO still accepts a grant when a response pops in the same cycle.
    assign rd_eligible = (count_q < CNT_MAX) || bus.dram_valid;

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .srstn (srstn),
        .en    (rd_eligible),
        .req   (bus.rd_req),
        .gnt   (rd_gnt)
    );

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .srstn (srstn),
        .en    (1'b1),
        .req   (bus.wr_req),
        .gnt   (wr_gnt)
    );

    assign rd_sel_addr = rd_gnt[RD_FMAP] ? bus.rd_addr[RD_FMAP*ADDR_WIDTH +: ADDR_WIDTH]
                                         : bus.rd_addr[RD_WEIGHT*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_sel_addr = wr_gnt[WR_POOL] ? bus.wr_addr[WR_POOL*ADDR_WIDTH +: ADDR_WIDTH]
                                         : bus.wr_addr[WR_CONV*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_sel_data = wr_gnt[WR_POOL] ? bus.wr_data[WR_POOL*DATA_WIDTH +: DATA_WIDTH]
                                         : bus.wr_data[WR_CONV*DATA_WIDTH +: DATA_WIDTH];

    // ID FIFO control
    assign push    = |rd_gnt;
    assign pop     = bus.dram_valid && (count_q != '0);
    assign head_id = id_mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        bus.rd_valid = '0;
        if (pop) begin
            bus.rd_valid[head_id] = 1'b1;
        end
    end

    assign bus.rd_data      = bus.dram_data_rd;
    assign bus.rd_gnt       = rd_gnt;
    assign bus.wr_gnt       = wr_gnt;
    assign bus.dram_en_rd   = en_rd_q;
    assign bus.dram_addr_rd = addr_rd_q;
    assign bus.dram_en_wr   = en_wr_q;
    assign bus.dram_addr_wr = addr_wr_q;
    assign bus.dram_data_wr = data_wr_q;
    assign bus.busy         = (count_q != '0) || en_rd_q || en_wr_q;
    assign bus.err          = err_q;

    // Storage needs no reset: entries are only read while count_q says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem_q[wr_ptr_q] <= rd_gnt[RD_FMAP];
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            en_rd_q   <= 1'b0;
            addr_rd_q <= '0;
            en_wr_q   <= 1'b0;
            addr_wr_q <= '0;
            data_wr_q <= '0;
        end else begin
            count_q <= count_d;
            en_rd_q <= push;
            en_wr_q <= |wr_gnt;
            if (push) begin
                wr_ptr_q  <= wr_ptr_q + 1'b1;
                addr_rd_q <= rd_sel_addr;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (bus.dram_valid && (count_q == '0)) begin
                err_q <= 1'b1;
            end
            if (|wr_gnt) begin
                addr_wr_q <= wr_sel_addr;
                data_wr_q <= wr_sel_data;
            end
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: scoreboard of issued reads checked against
// responses, round-robin reference for both channels, and a variable-latency DRAM model.
module tb_dram_arbiter;
    import lenet_pkg::*;

    localparam int unsigned AW   = 18;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXO = 4;

    logic clk   = 1'b0;
    logic srstn = 1'b1;
    always #5 clk = ~clk;

    dram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dram_arbiter #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk   (clk),
        .srstn (srstn),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic          client;
        logic [AW-1:0] addr;
    } rd_item_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            ready;
    } dram_item_t;

    rd_item_t   rd_sb[$];
    dram_item_t dram_q[$];
    logic [1:0] gnt_hist[$];

    logic          m_rd_last, m_wr_last, m_err;
    logic          exp_en_rd, exp_en_wr;
    logic [AW-1:0] exp_addr_rd, exp_addr_wr;
    logic [DW-1:0] exp_data_wr;
    int            rd_want[2], wr_want[2];
    logic [AW-1:0] rd_addr_n[2], wr_addr_n[2];
    logic [DW-1:0] wr_data_n[2];
    int            cyc, lat, both_cnt, rd_gnt_cnt;
    bit            hold, spurious, full_gnt_seen;

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return DW'(a) * 32'h9E37_79B1 + 32'h0000_1234;
    endfunction

    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) return last ? 2'b01 : 2'b10;
        return req;
    endfunction

    // One clock cycle; entered and left at posedge+1.
    task automatic cycle();
        logic [1:0]    rq, wq, eg_rd, eg_wr, ev;
        rd_item_t      it;
        bit            valid_now;
        int            size_before, c;

        check_eq("dram_en_rd", bus.dram_en_rd, exp_en_rd);
        if (exp_en_rd) check_eq("dram_addr_rd", bus.dram_addr_rd, exp_addr_rd);
        check_eq("dram_en_wr", bus.dram_en_wr, exp_en_wr);
        if (exp_en_wr) begin
            check_eq("dram_addr_wr", bus.dram_addr_wr, exp_addr_wr);
            check_eq("dram_data_wr", bus.dram_data_wr, exp_data_wr);
        end
        check_eq("busy", bus.busy, (rd_sb.size() != 0) || exp_en_rd || exp_en_wr);
        check_eq("err", bus.err, m_err);
        if (bus.dram_en_rd && bus.dram_en_wr) both_cnt++;
        if (bus.dram_en_rd) dram_q.push_back('{addr: bus.dram_addr_rd, ready: cyc + lat});

        for (int i = 0; i < 2; i++) begin
            rq[i] = rd_want[i] > 0;
            wq[i] = wr_want[i] > 0;
            bus.rd_addr[i*AW +: AW] = rd_addr_n[i];
            bus.wr_addr[i*AW +: AW] = wr_addr_n[i];
            bus.wr_data[i*DW +: DW] = wr_data_n[i];
        end
        bus.rd_req = rq;
        bus.wr_req = wq;
        valid_now = 1'b0;
        bus.dram_data_rd = $urandom;
        if (spurious) begin
            valid_now = 1'b1;
        end else if (!hold && dram_q.size() > 0 && dram_q[0].ready <= cyc) begin
            valid_now = 1'b1;
            bus.dram_data_rd = data_of(dram_q[0].addr);
            void'(dram_q.pop_front());
        end
        bus.dram_valid = valid_now;

        #3;
        size_before = rd_sb.size();
        eg_rd = (size_before < MAXO || valid_now) ? rr_pick(rq, m_rd_last) : 2'b00;
        eg_wr = rr_pick(wq, m_wr_last);
        ev = 2'b00;
        if (valid_now && size_before > 0) begin
            it = rd_sb.pop_front();
            ev[it.client] = 1'b1;
            check_eq("rd_data", bus.rd_data, data_of(it.addr));
        end else if (valid_now) begin
            m_err = 1'b1;
        end
        check_eq("rd_valid", bus.rd_valid, ev);
        check_eq("rd_gnt", bus.rd_gnt, eg_rd);
        check_eq("wr_gnt", bus.wr_gnt, eg_wr);

        if (bus.rd_gnt != 2'b00) begin
            gnt_hist.push_back(bus.rd_gnt);
            rd_gnt_cnt++;
            if (valid_now && size_before == MAXO) full_gnt_seen = 1'b1;
        end

        exp_en_rd = 1'b0;
        exp_en_wr = 1'b0;
        if (eg_rd != 2'b00) begin
            c = eg_rd[1] ? 1 : 0;
            rd_sb.push_back('{client: eg_rd[1], addr: rd_addr_n[c]});
            exp_en_rd   = 1'b1;
            exp_addr_rd = rd_addr_n[c];
            m_rd_last   = eg_rd[1];
            rd_want[c]--;
            rd_addr_n[c] = rd_addr_n[c] + 18'h41;
        end
        if (eg_wr != 2'b00) begin
            c = eg_wr[1] ? 1 : 0;
            exp_en_wr   = 1'b1;
            exp_addr_wr = wr_addr_n[c];
            exp_data_wr = wr_data_n[c];
            m_wr_last   = eg_wr[1];
            wr_want[c]--;
            wr_addr_n[c] = wr_addr_n[c] + 18'h7;
            wr_data_n[c] = wr_data_n[c] + 32'h0001_0003;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        while ((rd_sb.size() != 0 || dram_q.size() != 0 || exp_en_rd ||
                rd_want[0] > 0 || rd_want[1] > 0 || wr_want[0] > 0 || wr_want[1] > 0) && n < 80) begin
            cycle();
            n++;
        end
        check_eq("drain_done", (rd_sb.size() == 0 && rd_want[0] == 0 && rd_want[1] == 0), 1);
        cycle();
    endtask

    // Asynchronous reset asserted between clock edges; registered outputs must clear at once.
    task automatic async_reset();
        #1;
        srstn = 1'b0;
        #1;
        check_eq("rst_en_rd", bus.dram_en_rd, 0);
        check_eq("rst_addr_rd", bus.dram_addr_rd, 0);
        check_eq("rst_en_wr", bus.dram_en_wr, 0);
        check_eq("rst_addr_wr", bus.dram_addr_wr, 0);
        check_eq("rst_data_wr", bus.dram_data_wr, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_err", bus.err, 0);
        bus.rd_req = '0;
        bus.wr_req = '0;
        bus.dram_valid = 1'b0;
        rd_want = '{0, 0};
        wr_want = '{0, 0};
        rd_sb.delete();
        dram_q.delete();
        m_rd_last = 1'b1;
        m_wr_last = 1'b1;
        m_err     = 1'b0;
        exp_en_rd = 1'b0;
        exp_en_wr = 1'b0;
        @(posedge clk);
        #2;
        srstn = 1'b1;
        @(posedge clk);
        #1;
        cyc += 2;
    endtask

    initial begin
        bus.rd_req = '0; bus.rd_addr = '0; bus.wr_req = '0; bus.wr_addr = '0;
        bus.wr_data = '0; bus.dram_valid = 1'b0; bus.dram_data_rd = '0;
        cyc = 0; lat = 2; hold = 0; spurious = 0; both_cnt = 0; rd_gnt_cnt = 0;
        full_gnt_seen = 0;
        rd_addr_n = '{18'h01000, 18'h02000};
        wr_addr_n = '{18'h30000, 18'h30800};
        wr_data_n = '{32'hC0DE_0000, 32'hBEEF_0100};
        @(posedge clk);
        #1;
        async_reset();

        // Single read from client 0
        lat = 3;
        gnt_hist.delete();
        rd_addr_n[0] = 18'h00100;
        rd_want[0] = 1;
        drain();
        check_eq("single_gnt_cnt", gnt_hist.size(), 1);
        if (gnt_hist.size() > 0) check_eq("single_gnt", gnt_hist[0], 2'b01);

        // Contention after reset: strict alternation starting with client 0
        async_reset();
        lat = 2;
        gnt_hist.delete();
        rd_want = '{3, 3};
        drain();
        check_eq("alt_gnt_cnt", gnt_hist.size(), 6);
        for (int i = 0; i < gnt_hist.size() && i < 6; i++) begin
            check_eq("alt_gnt", gnt_hist[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        end

        // Capacity: responses held back, only MAXO grants until the first return
        hold = 1;
        lat = 1;
        rd_gnt_cnt = 0;
        rd_want = '{3, 3};
        repeat (8) cycle();
        check_eq("cap_grants", rd_gnt_cnt, MAXO);
        full_gnt_seen = 0;
        hold = 0;
        cycle();
        check_eq("cap_refill_gnt", full_gnt_seen, 1);
        drain();

        // Read and write channels together
        lat = 2;
        both_cnt = 0;
        rd_want = '{2, 2};
        wr_want = '{2, 2};
        repeat (6) cycle();
        check_eq("concurrent_cycles", both_cnt, 4);
        drain();

        // Spurious dram_valid sets a sticky error
        spurious = 1;
        cycle();
        spurious = 0;
        cycle();
        check_eq("err_set", bus.err, 1);
        rd_want = '{1, 1};
        wr_want = '{1, 0};
        drain();
        check_eq("err_sticky", bus.err, 1);

        // Reset with three reads in flight, then a tie goes to client 0
        hold = 1;
        rd_want = '{2, 1};
        repeat (4) cycle();
        check_eq("midburst_busy", bus.busy, 1);
        async_reset();
        hold = 0;
        gnt_hist.delete();
        rd_want = '{1, 1};
        drain();
        check_eq("post_rst_gnt_cnt", gnt_hist.size(), 2);
        if (gnt_hist.size() > 0) check_eq("post_rst_first", gnt_hist[0], 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
Shares the single DRAM model port pair (independent read and write channels) between two read clients and two write clients inside lenet.
- Read clients: 0 = weight/bias fetch, 1 = feature-map fetch.
- Write clients: 0 = conv/relu output, 1 = pool output.
- Each channel uses independent round-robin arbitration.
- Read responses, which arrive on dram_valid with variable latency, are routed back to the issuing client through an in-order ID FIFO.

Parameters:
- DATA_WIDTH, 32, DRAM word width.
- ADDR_WIDTH, 18, DRAM word address width.
- MAX_OUTSTANDING, 4, max in-flight reads and ID FIFO depth; power of 2, ≥2.

Ports:
- clk  in  1  clock
- srstn  in  1  asynchronous active-low reset
- rd_req  in  2  per-client read request; held until granted
- rd_addr  in  2*ADDR_WIDTH  client i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_gnt  out  2  one-hot read grant, combinational
- rd_valid  out  2  one-hot response strobe to the issuing client
- rd_data  out  DATA_WIDTH  response data, shared by both clients
- wr_req  in  2  per-client write request; held until granted
- wr_addr  in  2*ADDR_WIDTH  packed write addresses
- wr_data  in  2*DATA_WIDTH  packed write data
- wr_gnt  out  2  one-hot write grant, combinational
- dram_en_rd  out  1  DRAM read enable, registered
- dram_addr_rd  out  ADDR_WIDTH  DRAM read address, registered
- dram_valid  in  1  DRAM read data valid
- dram_data_rd  in  DATA_WIDTH  DRAM read data
- dram_en_wr  out  1  DRAM write enable, registered
- dram_addr_wr  out  ADDR_WIDTH  DRAM write address, registered
- dram_data_wr  out  DATA_WIDTH  DRAM write data, registered
- busy  out  1  outstanding reads exist or a DRAM command is registered this cycle
- err  out  1  sticky: dram_valid arrived with no read outstanding

Behaviour:
Reset:
- All registered outputs are 0 and err = 0.
- Both channels' last-granted pointers = 1, so client 0 wins the first tie.
- ID FIFO is empty and the outstanding count is 0.

Handshake:
- A client asserts req with stable addr/data until it sees gnt high in the same cycle.
- The client may drop or change the request in the cycle after the grant.
- gnt is never asserted without the corresponding req.

Read arbitration (cycle T):
- The channel is eligible when count < MAX_OUTSTANDING, or when count == MAX_OUTSTANDING and dram_valid = 1 in T (simultaneous pop frees a slot).
- With one requester, grant it. With both, grant the one that is not last-granted. Update last-granted on each grant.
- On grant: push the client ID into the FIFO. At T+1, dram_en_rd = 1 and dram_addr_rd = the granted address. Otherwise dram_en_rd = 0 and the address holds.
- At most one grant per cycle; back-to-back grants are allowed every cycle.

Read return:
- When dram_valid = 1 and the FIFO is non-empty: pop the head ID, assert rd_valid[id] in the same cycle (combinational), and drive rd_data = dram_data_rd (pass-through).
- Push and pop in the same cycle: count is unchanged and the pointers both advance.
- When dram_valid = 1 with the FIFO empty: no rd_valid, and err is set and stays set until reset.

Write channel:
- Same round-robin as the read channel, with no capacity limit.
- Grant at T drives dram_en_wr/addr/data at T+1 for exactly one cycle.
- The read and write channels operate fully concurrently.

FIFO and pointers:
- Pointers are log2(MAX_OUTSTANDING) bits and wrap naturally.
- count is log2(MAX_OUTSTANDING)+1 bits.

Mid-operation reset:
- All state clears immediately.
- Any DRAM responses still in flight after reset release hit the empty-FIFO case and set err. The controller must drain reads before reset.

Decomposition:
- Shared package lenet_pkg holds: client ID localparams (RD_WEIGHT=0, RD_FMAP=1, WR_CONV=0, WR_POOL=1), the NUM_CLIENTS=2 constant, and the DATA_WIDTH/ADDR_WIDTH defaults.
- One natural sub-module, rr_arb2: a two-input round-robin arbiter with a last-granted register and an enable input. It is instantiated twice (read channel, write channel).
- The ID FIFO stays inline.

Test Plan:
- Single read: rd_req=01, addr0=0x00100 -> rd_gnt=01 at T; dram_en_rd=1, addr=0x00100 at T+1; the DRAM model's valid pulses rd_valid=01 with the stored word; count returns to 0.
- Contention: both rd_req held for 6 grants -> grants alternate 01,10,01,10,... starting with client 0 after reset; response order matches grant order.
- Capacity: DRAM valid delayed, both clients requesting continuously -> exactly 4 grants, then rd_gnt=00 until the first dram_valid; in that same cycle a fifth grant is issued and count stays at 4.
- Concurrent channels: rd_req=11 and wr_req=11 for 4 cycles -> the DRAM sees reads and writes in the same cycles; write addr/data match the granted client each cycle with alternating clients.
- Spurious valid: dram_valid=1 with nothing outstanding -> rd_valid=00 and err=1, which stays 1 through later traffic until srstn=0.
- Reset mid-burst: 3 reads outstanding, srstn pulsed low asynchronously between clock edges -> outputs 0, count 0, busy 0 immediately; after release, client 0 wins the first tie.
